// File: rtl/tt_um_adder_exerciser_if.sv
// Pin bundle between the adder exerciser and the board-level harness.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-sampled pins.
interface tt_um_adder_exerciser_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Harness side: drives the dedicated inputs and the returned adder result
    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    // Exerciser side
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_adder_exerciser.sv
// Sweeps all 256 operand pairs into a registered 4-bit adder and checks each returned sum.
// Latency: SETTLE_CYCLES per vector; done asserts the cycle after the last compare.
// Backpressure: none; ena=0 freezes every register and holds the outputs.
module tt_um_adder_exerciser #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tt_um_adder_exerciser_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [7:0]       err_cnt;
    logic [7:0]       first_fail;
    logic             fail_seen;
    logic             start_q;

    logic             start_edge;
    logic [4:0]       expected;
    logic             mismatch;
    logic             busy;
    logic             done;
    logic             pass;
    logic             unused_pins;

    assign start_edge = bus.ui_in[0] & ~start_q;
    // Full 5-bit sum so a dropped carry is caught as a mismatch
    assign expected   = {1'b0, idx[3:0]} + {1'b0, idx[7:4]};
    assign mismatch   = (bus.uio_in[4:0] != expected);

    // Sweep sequencer, scoreboard counters and start-edge detector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 8'd0;
            settle_cnt <= '0;
            err_cnt    <= 8'd0;
            first_fail <= 8'd0;
            fail_seen  <= 1'b0;
            start_q    <= 1'b1;
        end else if (bus.ena) begin
            start_q <= bus.ui_in[0];
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state      <= DRIVE;
                        idx        <= 8'd0;
                        settle_cnt <= '0;
                        err_cnt    <= 8'd0;
                        first_fail <= 8'd0;
                        fail_seen  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        if (mismatch) begin
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            if (!fail_seen) begin
                                first_fail <= idx;
                                fail_seen  <= 1'b1;
                            end
                        end
                        if (mismatch && bus.ui_in[1]) begin
                            state <= DONE;
                        end else if (idx == 8'hFF) begin
                            state <= DONE;
                        end else begin
                            idx        <= idx + 8'd1;
                            settle_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == DRIVE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 8'd0);

    // Operand drive while sweeping, readout byte once finished
    always_comb begin
        bus.uo_out = 8'h00;
        case (state)
            DRIVE:   bus.uo_out = idx;
            DONE:    bus.uo_out = bus.ui_in[3] ? first_fail : err_cnt;
            default: bus.uo_out = 8'h00;
        endcase
    end

    assign bus.uio_out = {done, pass, busy, 5'b0_0000};
    assign bus.uio_oe  = 8'b1110_0000;

    // Pins that carry nothing for this tile
    assign unused_pins = ^{bus.ui_in[7:4], bus.ui_in[2], bus.uio_in[7:5]};
endmodule
